// File: rtl/field_slicer_pkg.sv
// Shared types, default sizes and helpers for the field_slicer block.
package field_slicer_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_FIELD_W = 8;
   localparam int DEF_NUM_CH  = 4;

   typedef logic [DEF_FIELD_W-1:0] field_t;
   typedef logic [DEF_DATA_W-1:0]  word_t;

   // Why a configuration write was refused.
   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_RANGE,
      ERR_CH
   } cfg_err_e;

   // Reset LSB of a channel: channels tile the word, folded back into the legal offset range.
   function automatic int lsb_default(input int ch, input int field_w, input int data_w);
      return (ch * field_w) % (data_w - field_w + 1);
   endfunction

endpackage

// File: rtl/field_slicer_if.sv
// Word-in / fields-out valid-ready stream bundle for field_slicer.
interface field_slicer_if
   import field_slicer_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int NUM_CH  = DEF_NUM_CH
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_W-1:0]         in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_CH*FIELD_W-1:0] out_fields;

   // Source of words / sink of fields.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_fields
   );

   // The slicer itself.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_fields
   );
endinterface

// File: rtl/field_slicer_skid.sv
// Generic valid/ready output register with a one-entry skid buffer.
// Full throughput; ready is registered (depends only on skid occupancy).
module field_slicer_skid #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [WIDTH-1:0] s_data_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o
);
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic             rst_done_q;
   logic             s_acc;

   // Ready stays low during reset and comes up on the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_done_q <= 1'b0;
      else        rst_done_q <= 1'b1;
   end

   assign s_ready_o = rst_done_q & ~skid_valid_q;
   assign s_acc     = s_valid_i & s_ready_o;

   // Next state: refill the output register from skid first, else from input; park in skid on stall.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || m_ready_i) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (s_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = s_data_i;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (s_acc) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_data_i;
      end
   end

   // State registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign m_valid_o = out_valid_q;
   assign m_data_o  = out_data_q;

endmodule

// File: rtl/field_slicer.sv
// field_slicer: slices each accepted word into NUM_CH fields at runtime-programmable offsets.
// Optional beat counter enabled by defining FIELD_SLICER_STATS_EN; otherwise stat_beats is 0.
module field_slicer
   import field_slicer_pkg::*;
#(
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int FIELD_W = DEF_FIELD_W,
   parameter  int NUM_CH  = DEF_NUM_CH,
   localparam int LSB_W   = $clog2(DATA_W),
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   field_slicer_if.slave    bus,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [LSB_W-1:0] cfg_lsb,
   output logic             cfg_err,
   output logic [31:0]      stat_beats
);
   localparam int MAX_LSB = DATA_W - FIELD_W;
   localparam int CH_SPAN = 1 << CH_W;

   logic [CH_SPAN-1:0]        ch_ok;
   logic [NUM_CH*FIELD_W-1:0] fields;
   cfg_err_e                  err_reason;
   logic                      cfg_ok;
   logic                      cfg_err_q;

   // Channel indices the cfg_ch encoding can express but that do not exist.
   for (genvar gi = 0; gi < CH_SPAN; gi++) begin : g_ch_ok
      assign ch_ok[gi] = (gi < NUM_CH);
   end

   // Classify the config write.
   always_comb begin
      err_reason = ERR_NONE;
      if (cfg_we) begin
         if (!ch_ok[cfg_ch])                     err_reason = ERR_CH;
         else if (cfg_lsb > LSB_W'(MAX_LSB))     err_reason = ERR_RANGE;
      end
   end

   assign cfg_ok = (err_reason == ERR_NONE);

   // Reject flag is registered so it pulses in the cycle after the offending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_err_q <= 1'b0;
      else        cfg_err_q <= cfg_we & ~cfg_ok;
   end

   assign cfg_err = cfg_err_q;

   // Per-channel offset register and slicer; the slice uses the offset held before any same-cycle write.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [LSB_W-1:0] lsb_q;

      // Offset register for this channel.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            lsb_q <= LSB_W'(lsb_default(gi, FIELD_W, DATA_W));
         else if (cfg_we && cfg_ok && (cfg_ch == CH_W'(gi)))
            lsb_q <= cfg_lsb;
      end

      assign fields[gi*FIELD_W +: FIELD_W] = bus.in_data[lsb_q +: FIELD_W];
   end

   field_slicer_skid #(.WIDTH(NUM_CH*FIELD_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid_i (bus.in_valid),
      .s_ready_o (bus.in_ready),
      .s_data_i  (fields),
      .m_valid_o (bus.out_valid),
      .m_ready_i (bus.out_ready),
      .m_data_o  (bus.out_fields)
   );

`ifdef FIELD_SLICER_STATS_EN
   logic [31:0] stat_q;

   // Saturating count of output handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stat_q <= '0;
      else if (bus.out_valid && bus.out_ready && (stat_q != 32'hFFFF_FFFF))
         stat_q <= stat_q + 32'd1;
   end

   assign stat_beats = stat_q;
`else
   assign stat_beats = 32'h0;
`endif

endmodule

// File: tb/tb_field_slicer.sv
// Self-checking bench for field_slicer (DATA_W=32, FIELD_W=8, NUM_CH=4).
module tb_field_slicer;
   import field_slicer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [4:0] cfg_lsb;
   logic       cfg_err;
   logic [31:0] stat_beats;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   field_slicer_if #(.DATA_W(32), .FIELD_W(8), .NUM_CH(4)) bus ();

   field_slicer #(.DATA_W(32), .FIELD_W(8), .NUM_CH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_lsb    (cfg_lsb),
      .cfg_err    (cfg_err),
      .stat_beats (stat_beats)
   );

   typedef struct {
      logic       we;
      logic [1:0] ch;
      logic [4:0] lsb;
      word_t      data;
      word_t      exp_fields;
      logic       exp_err;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] q[$];
      logic [31:0] exp_word;
      int sent, got, cyc;

      // Beat i uses the offsets in force before its own cfg write; offsets evolve down the table.
      vecs[0]  = '{1'b0, 2'd0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0};
      vecs[1]  = '{1'b1, 2'd0, 5'd4,  32'h1234_5678, 32'h1234_5678, 1'b0};
      vecs[2]  = '{1'b0, 2'd0, 5'd0,  32'h1234_5678, 32'h1234_5667, 1'b0};
      vecs[3]  = '{1'b1, 2'd1, 5'd25, 32'h1234_5678, 32'h1234_5667, 1'b1};
      vecs[4]  = '{1'b0, 2'd0, 5'd0,  32'h1234_5678, 32'h1234_5667, 1'b0};
      vecs[5]  = '{1'b1, 2'd2, 5'd24, 32'hAABB_CCDD, 32'hAABB_CCCD, 1'b0};
      vecs[6]  = '{1'b0, 2'd0, 5'd0,  32'hAABB_CCDD, 32'hAAAA_CCCD, 1'b0};
      vecs[7]  = '{1'b1, 2'd3, 5'd0,  32'hF0E1_D2C3, 32'hF0F0_D22C, 1'b0};
      vecs[8]  = '{1'b0, 2'd0, 5'd0,  32'hF0E1_D2C3, 32'hC3F0_D22C, 1'b0};
      vecs[9]  = '{1'b1, 2'd0, 5'd24, 32'h8000_0001, 32'h0180_0000, 1'b0};
      vecs[10] = '{1'b0, 2'd0, 5'd0,  32'h8000_0001, 32'h0180_0080, 1'b0};
      vecs[11] = '{1'b1, 2'd1, 5'd31, 32'h1234_5678, 32'h7812_5612, 1'b1};
      vecs[12] = '{1'b0, 2'd0, 5'd0,  32'h1234_5678, 32'h7812_5612, 1'b0};

      cfg_we = 1'b0; cfg_ch = '0; cfg_lsb = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out_fields", bus.out_fields, 32'h0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      chk("rst_stat", stat_beats, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready_low", bus.in_ready, 1'b0);
      tick();
      chk("release_in_ready_high", bus.in_ready, 1'b1);

      // Default offsets reproduce the word
      bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678;
      tick();
      bus.in_valid = 1'b0;
      chk("dflt_valid", bus.out_valid, 1'b1);
      chk("dflt_fields", bus.out_fields, 32'h1234_5678);
      tick();
      chk("dflt_drained", bus.out_valid, 1'b0);

      // Backpressure: A in output, B in skid, C held off
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'hA1A2_A3A4;
      tick();
      chk("bp_a_out", bus.out_fields, 32'hA1A2_A3A4);
      chk("bp_ready_after_a", bus.in_ready, 1'b1);
      bus.in_data = 32'hB1B2_B3B4;
      tick();
      chk("bp_ready_after_b", bus.in_ready, 1'b0);
      chk("bp_a_held", bus.out_fields, 32'hA1A2_A3A4);
      bus.in_data = 32'hC1C2_C3C4;
      tick();
      chk("bp_c_blocked", bus.in_ready, 1'b0);
      chk("bp_a_stable", bus.out_fields, 32'hA1A2_A3A4);
      chk("bp_valid_stall", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_b_out", bus.out_fields, 32'hB1B2_B3B4);
      chk("bp_ready_back", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_c_out", bus.out_fields, 32'hC1C2_C3C4);
      chk("bp_c_valid", bus.out_valid, 1'b1);
      tick();
      chk("bp_empty", bus.out_valid, 1'b0);

      // Table of config writes and beats
      for (int i = 0; i < 13; i++) begin
         cfg_we = vecs[i].we; cfg_ch = vecs[i].ch; cfg_lsb = vecs[i].lsb;
         bus.in_valid = 1'b1; bus.in_data = vecs[i].data;
         tick();
         cfg_we = 1'b0; bus.in_valid = 1'b0;
         $display("vec %0d: we=%0b ch=%0d lsb=%0d data=%h -> fields=%h err=%0b", i,
                  vecs[i].we, vecs[i].ch, vecs[i].lsb, vecs[i].data, bus.out_fields, cfg_err);
         chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
         chk($sformatf("vec%0d_fields", i), bus.out_fields, vecs[i].exp_fields);
         chk($sformatf("vec%0d_err", i), cfg_err, vecs[i].exp_err);
         tick();
         chk($sformatf("vec%0d_err_clear", i), cfg_err, 1'b0);
      end

      // Back-to-back rejects keep cfg_err high
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_lsb = 5'd30;
      tick();
      cfg_ch = 2'd3; cfg_lsb = 5'd26;
      chk("b2b_err_first", cfg_err, 1'b1);
      tick();
      cfg_we = 1'b0;
      chk("b2b_err_second", cfg_err, 1'b1);
      tick();
      chk("b2b_err_clear", cfg_err, 1'b0);

      // Reset mid-stream with output register and skid occupied
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'h0BAD_0001;
      tick();
      bus.in_data = 32'h0BAD_0002;
      tick();
      bus.in_valid = 1'b0;
      chk("mid_full_valid", bus.out_valid, 1'b1);
      chk("mid_full_ready", bus.in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 1'b0);
      chk("mid_rst_ready", bus.in_ready, 1'b0);
      chk("mid_rst_fields", bus.out_fields, 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rel_ready", bus.in_ready, 1'b1);
      chk("mid_rel_valid", bus.out_valid, 1'b0);
      chk("mid_rel_stat", stat_beats, 32'h0);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678;
      tick();
      bus.in_valid = 1'b0;
      chk("mid_dflt_fields", bus.out_fields, 32'h1234_5678);
      tick();

      // 100 beats with random backpressure; offsets are defaults so fields equal the word
      sent = 0; got = 0; cyc = 0;
      while (got < 100 && cyc < 3000) begin
         bus.out_ready = ($urandom_range(0, 1) == 1);
         if (sent < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data = $urandom;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(bus.in_data);
            sent++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("stream_underflow", 1'b1, 1'b0);
            end else begin
               exp_word = q.pop_front();
               chk("stream_order", bus.out_fields, exp_word);
            end
            got++;
         end
         tick();
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("stream_count", got, 100);
      chk("stream_leftover", q.size(), 0);
      $display("stream: %0d beats in %0d cycles, stat_beats=%0d", got, cyc, stat_beats);
`ifdef FIELD_SLICER_STATS_EN
      // One default-check beat after reset plus the 100 streamed beats
      chk("stat_beats", stat_beats, 32'd101);
`else
      chk("stat_beats", stat_beats, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
